// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module  : imm_gen_pipe
// Brief   : Multi-lane RV32I immediate decoder with a 2-entry valid/ready buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module imm_gen_pipe #(
    parameter int LANES = 1,
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*32-1:0]     in_inst,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*XLEN-1:0]   out_imm,
    output logic [LANES*3-1:0]      out_fmt,
    output logic [LANES-1:0]        out_illegal,
    output logic [CNT_W-1:0]        illegal_cnt
);

    localparam logic [2:0] c_FMT_R   = 3'd0;
    localparam logic [2:0] c_FMT_I   = 3'd1;
    localparam logic [2:0] c_FMT_S   = 3'd2;
    localparam logic [2:0] c_FMT_B   = 3'd3;
    localparam logic [2:0] c_FMT_U   = 3'd4;
    localparam logic [2:0] c_FMT_J   = 3'd5;
    localparam logic [2:0] c_FMT_ILL = 3'd7;

    localparam int              c_LW      = $clog2(LANES + 1);
    localparam int              c_SUM_W   = CNT_W + c_LW;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [LANES*XLEN-1:0] w_imm;
    logic [LANES*3-1:0]    w_fmt;
    logic [LANES-1:0]      w_ill;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [31:0] w_inst;
        logic [31:0] w_imm32;
        logic [2:0]  w_f;

        assign w_inst = in_inst[32*k +: 32];

        always_comb begin
            w_f = c_FMT_ILL;
            case (w_inst[6:0])
                7'b0110011:                        w_f = c_FMT_R;
                7'b0000011, 7'b0010011, 7'b1100111,
                7'b0001111, 7'b1110011:            w_f = c_FMT_I;
                7'b0100011:                        w_f = c_FMT_S;
                7'b1100011:                        w_f = c_FMT_B;
                7'b0110111, 7'b0010111:            w_f = c_FMT_U;
                7'b1101111:                        w_f = c_FMT_J;
                default:                           w_f = c_FMT_ILL;
            endcase
        end

        // Shift immediates are not special-cased: funct7 stays in imm[11:5].
        always_comb begin
            w_imm32 = '0;
            case (w_f)
                c_FMT_I: w_imm32 = {{21{w_inst[31]}}, w_inst[30:20]};
                c_FMT_S: w_imm32 = {{21{w_inst[31]}}, w_inst[30:25], w_inst[11:7]};
                c_FMT_B: w_imm32 = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25],
                                    w_inst[11:8], 1'b0};
                c_FMT_U: w_imm32 = {w_inst[31:12], 12'b0};
                c_FMT_J: w_imm32 = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20],
                                    w_inst[30:21], 1'b0};
                default: w_imm32 = '0;
            endcase
        end

        if (XLEN > 32) begin : g_sext
            assign w_imm[XLEN*k +: XLEN] = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_nosext
            assign w_imm[XLEN*k +: XLEN] = w_imm32;
        end

        assign w_fmt[3*k +: 3] = w_f;
        assign w_ill[k]        = (w_f == c_FMT_ILL);
    end

    logic                  w_push;
    logic                  w_pop;
    logic [1:0]            count_q, count_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  in_ready_q;
    logic [CNT_W-1:0]      illegal_cnt_q, illegal_cnt_d;
    logic [c_LW-1:0]       w_ill_n;
    logic [c_SUM_W-1:0]    w_sum;
    logic [LANES*XLEN-1:0] imm_q [2];
    logic [LANES*3-1:0]    fmt_q [2];
    logic [LANES-1:0]      ill_q [2];

    assign w_push = in_valid && in_ready_q && !flush;
    assign w_pop  = (count_q != 2'd0) && out_ready;

    always_comb begin
        w_ill_n = '0;
        for (int k = 0; k < LANES; k++) begin
            w_ill_n = w_ill_n + c_LW'(w_ill[k]);
        end
    end

    assign w_sum = c_SUM_W'(illegal_cnt_q) + c_SUM_W'(w_ill_n);

    always_comb begin
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        illegal_cnt_d = illegal_cnt_q;
        // Pointers are rewound on flush so an empty buffer always has wr == rd.
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_d = ~wr_ptr_q;
                illegal_cnt_d = (w_sum > c_SUM_W'(c_CNT_MAX)) ? c_CNT_MAX
                                                              : w_sum[CNT_W-1:0];
            end
            if (w_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q       <= 2'd0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            in_ready_q    <= 1'b1;
            illegal_cnt_q <= '0;
            for (int i = 0; i < 2; i++) begin
                imm_q[i] <= '0;
                fmt_q[i] <= '0;
                ill_q[i] <= '0;
            end
        end else begin
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            in_ready_q    <= (count_d != 2'd2);
            illegal_cnt_q <= illegal_cnt_d;
            if (w_push) begin
                imm_q[wr_ptr_q] <= w_imm;
                fmt_q[wr_ptr_q] <= w_fmt;
                ill_q[wr_ptr_q] <= w_ill;
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (count_q != 2'd0);
    assign out_imm     = imm_q[rd_ptr_q];
    assign out_fmt     = fmt_q[rd_ptr_q];
    assign out_illegal = ill_q[rd_ptr_q];
    assign illegal_cnt = illegal_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// Module  : tb_imm_gen_pipe
// Brief   : Self-checking bench for imm_gen_pipe (scoreboard on the main DUT)
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_imm_gen_pipe;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [31:0] inst;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    // Main DUT: LANES=1, XLEN=32, CNT_W=16
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;
    logic [15:0] illegal_cnt;

    // XLEN=64 instance
    logic        v64, r64, ov64;
    logic [31:0] i64;
    logic [63:0] imm64;
    logic [2:0]  f64;
    logic        il64;
    logic [15:0] c64;

    // LANES=2 instance
    logic        v2, r2, ov2;
    logic [63:0] i2;
    logic [63:0] imm2;
    logic [5:0]  f2;
    logic [1:0]  il2;
    logic [15:0] c2;

    // CNT_W=2 instance
    logic        vc, rc, ovc;
    logic [31:0] ic, immc;
    logic [2:0]  fc;
    logic        ilc;
    logic [1:0]  cc;

    imm_gen_pipe u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    imm_gen_pipe #(.LANES(1), .XLEN(64), .CNT_W(16)) u_dut64 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(v64), .in_ready(r64), .in_inst(i64),
        .out_valid(ov64), .out_ready(1'b1),
        .out_imm(imm64), .out_fmt(f64), .out_illegal(il64),
        .illegal_cnt(c64)
    );

    imm_gen_pipe #(.LANES(2), .XLEN(32), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(v2), .in_ready(r2), .in_inst(i2),
        .out_valid(ov2), .out_ready(1'b1),
        .out_imm(imm2), .out_fmt(f2), .out_illegal(il2),
        .illegal_cnt(c2)
    );

    imm_gen_pipe #(.LANES(1), .XLEN(32), .CNT_W(2)) u_dutc (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(vc), .in_ready(rc), .in_inst(ic),
        .out_valid(ovc), .out_ready(1'b1),
        .out_imm(immc), .out_fmt(fc), .out_illegal(ilc),
        .illegal_cnt(cc)
    );

    exp_t        sb[$];
    vec_t        vecs [10];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] exp_cnt = '0;

    task automatic init_vectors();
        vecs[0] = '{32'hFFF00093, '{32'hFFFFFFFF, 3'd1, 1'b0}};  // addi -1
        vecs[1] = '{32'h0020A423, '{32'h00000008, 3'd2, 1'b0}};  // sw 8
        vecs[2] = '{32'hFE000EE3, '{32'hFFFFFFFC, 3'd3, 1'b0}};  // beq -4
        vecs[3] = '{32'h123450B7, '{32'h12345000, 3'd4, 1'b0}};  // lui
        vecs[4] = '{32'h0010006F, '{32'h00000800, 3'd5, 1'b0}};  // jal +2048
        vecs[5] = '{32'h0000007F, '{32'h00000000, 3'd7, 1'b1}};  // illegal
        vecs[6] = '{32'h002081B3, '{32'h00000000, 3'd0, 1'b0}};  // add (R)
        vecs[7] = '{32'h00509093, '{32'h00000005, 3'd1, 1'b0}};  // slli 5
        vecs[8] = '{32'h40509093, '{32'h00000405, 3'd1, 1'b0}};  // srai 5
        vecs[9] = '{32'h80000017, '{32'h80000000, 3'd4, 1'b0}};  // auipc
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b0;
        v64 = 1'b0; i64 = '0; v2 = 1'b0; i2 = '0; vc = 1'b0; ic = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 32'h0 ||
            out_fmt !== 3'd0 || out_illegal !== 1'b0 || illegal_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset: valid=%b ready=%b imm=%h fmt=%0d ill=%b cnt=%0d, required 0 1 0 0 0 0",
                     out_valid, in_ready, out_imm, out_fmt, out_illegal, illegal_cnt);
        end
    endtask

    task automatic test_formats();
        exp_t e, got;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_inst  = vecs[i].inst;
            n_chk++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fmt_ready[%0d]: in_ready=%b, required 1", i, in_ready);
            end
            sb.push_back(vecs[i].e);
            if (vecs[i].e.ill) exp_cnt++;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            e   = sb.pop_front();
            got = {out_imm, out_fmt, out_illegal};
            n_chk++;
            if (out_valid !== 1'b1 || got !== e) begin
                n_fail++;
                $display("FAIL fmt[%0d] inst=%h: valid=%b imm=%h fmt=%0d ill=%b, required 1 %h %0d %b",
                         i, vecs[i].inst, out_valid, out_imm, out_fmt, out_illegal,
                         e.imm, e.fmt, e.ill);
            end
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || illegal_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL fmt_drain: valid=%b cnt=%0d, required 0 %0d",
                     out_valid, illegal_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int   sel [3];
        int   idx;
        int   got_n;
        logic acc;
        exp_t e, got;
        sel[0] = 1; sel[1] = 3; sel[2] = 4;
        idx = 0; got_n = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = vecs[sel[0]].inst;
        for (int cyc = 0; cyc < 30 && got_n < 3; cyc++) begin
            out_ready = (cyc >= 4);
            if (cyc == 2 || cyc == 3) begin
                n_chk++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_imm !== vecs[sel[0]].e.imm) begin
                    n_fail++;
                    $display("FAIL b2b_full[%0d]: ready=%b valid=%b imm=%h, required 0 1 %h",
                             cyc, in_ready, out_valid, out_imm, vecs[sel[0]].e.imm);
                end
            end
            if (out_valid && out_ready) begin
                got = {out_imm, out_fmt, out_illegal};
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: unexpected output imm=%h", out_imm);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL b2b_order[%0d]: imm=%h fmt=%0d, required %h %0d",
                                 got_n, out_imm, out_fmt, e.imm, e.fmt);
                    end
                end
                got_n++;
            end
            acc = in_valid && in_ready;
            if (acc) sb.push_back(vecs[sel[idx]].e);
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 3) in_inst = vecs[sel[idx]].inst;
                else         in_valid = 1'b0;
            end
        end
        n_chk++;
        if (got_n != 3 || sb.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done: outputs=%0d left=%0d valid=%b, required 3 0 0",
                     got_n, sb.size(), out_valid);
        end
        sb.delete();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = vecs[0].inst;
        @(posedge clk); #1;
        in_inst = vecs[2].inst;
        @(posedge clk); #1;
        n_chk++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre: ready=%b valid=%b, required 0 1", in_ready, out_valid);
        end
        flush = 1'b1; in_inst = 32'h0000007F;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_full: valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
        // One entry buffered, then flush racing a push of an illegal opcode
        in_valid = 1'b1; in_inst = vecs[3].inst;
        @(posedge clk); #1;
        flush = 1'b1; in_inst = 32'h0000007F;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0 || illegal_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL flush_push: valid=%b cnt=%0d, required 0 %0d",
                     out_valid, illegal_cnt, exp_cnt);
        end
        out_ready = 1'b1; in_valid = 1'b1; in_inst = vecs[4].inst;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b1 || out_imm !== vecs[4].e.imm || out_fmt !== vecs[4].e.fmt) begin
            n_fail++;
            $display("FAIL flush_after: valid=%b imm=%h fmt=%0d, required 1 %h %0d",
                     out_valid, out_imm, out_fmt, vecs[4].e.imm, vecs[4].e.fmt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = vecs[0].inst;
        @(posedge clk); #1;
        in_inst = vecs[2].inst;
        @(posedge clk); #2;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        exp_cnt = '0;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 32'h0 ||
            out_fmt !== 3'd0 || out_illegal !== 1'b0 || illegal_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b ready=%b imm=%h fmt=%0d ill=%b cnt=%0d, required 0 1 0 0 0 0",
                     out_valid, in_ready, out_imm, out_fmt, out_illegal, illegal_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b1; in_inst = vecs[3].inst; out_ready = 1'b1;
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b1 || out_imm !== vecs[3].e.imm) begin
            n_fail++;
            $display("FAIL reset_first_push: valid=%b imm=%h, required 1 %h",
                     out_valid, out_imm, vecs[3].e.imm);
        end
    endtask

    task automatic test_xlen64();
        logic [63:0] exp64 [3];
        int          sel [3];
        sel[0] = 2; sel[1] = 3; sel[2] = 9;
        exp64[0] = 64'hFFFFFFFFFFFFFFFC;
        exp64[1] = 64'h0000000012345000;
        exp64[2] = 64'hFFFFFFFF80000000;
        for (int i = 0; i < 3; i++) begin
            v64 = 1'b1; i64 = vecs[sel[i]].inst;
            @(posedge clk); #1;
            v64 = 1'b0;
            n_chk++;
            if (ov64 !== 1'b1 || imm64 !== exp64[i] || f64 !== vecs[sel[i]].e.fmt) begin
                n_fail++;
                $display("FAIL xlen64[%0d]: valid=%b imm=%h fmt=%0d, required 1 %h %0d",
                         i, ov64, imm64, f64, exp64[i], vecs[sel[i]].e.fmt);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lanes2();
        v2 = 1'b1; i2 = {32'h0000007F, 32'h0000007F};
        @(posedge clk); #1;
        i2 = {32'hFFF00093, 32'h0000007F};
        n_chk++;
        if (ov2 !== 1'b1 || il2 !== 2'b11 || f2 !== {3'd7, 3'd7} || imm2 !== 64'h0 || c2 !== 16'd2) begin
            n_fail++;
            $display("FAIL lanes2_both: valid=%b ill=%b fmt=%h imm=%h cnt=%0d, required 1 11 3f 0 2",
                     ov2, il2, f2, imm2, c2);
        end
        @(posedge clk); #1;
        v2 = 1'b0;
        n_chk++;
        if (il2 !== 2'b01 || f2 !== {3'd1, 3'd7} || imm2 !== 64'hFFFFFFFF_00000000 || c2 !== 16'd3) begin
            n_fail++;
            $display("FAIL lanes2_mixed: ill=%b fmt=%h imm=%h cnt=%0d, required 01 0f ffffffff00000000 3",
                     il2, f2, imm2, c2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal_sat();
        logic [1:0] exp_c;
        exp_c = '0;
        for (int n = 1; n <= 5; n++) begin
            vc = 1'b1; ic = 32'h0000007F;
            @(posedge clk); #1;
            vc = 1'b0;
            if (exp_c != 2'd3) exp_c++;
            n_chk++;
            if (cc !== exp_c || fc !== 3'd7 || ilc !== 1'b1 || immc !== 32'h0) begin
                n_fail++;
                $display("FAIL illegal_sat[%0d]: cnt=%0d fmt=%0d ill=%b imm=%h, required %0d 7 1 0",
                         n, cc, fc, ilc, immc, exp_c);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        init_vectors();
        test_reset();
        test_formats();
        test_back_to_back();
        test_flush();
        test_xlen64();
        test_lanes2();
        test_illegal_sat();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
